// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store issue unit: decode masks,
// LSU FSM states, and the issue-queue entry layout.
package lsu_pkg;

  localparam int LSU_INST_ID_BITS = 6;
  localparam int LSU_PRN_BITS     = 6;
  localparam int LSU_MAX_OPERANDS = 3;

  localparam logic [31:0] LDST_MASK  = 32'hFFE0_0C00;
  localparam logic [31:0] LDUR_MATCH = 32'hF840_0000;
  localparam logic [31:0] STUR_MATCH = 32'hF800_0000;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_LOAD_WAIT,
    LSU_STORE,
    LSU_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_LOAD,
    OP_STORE
  } lsu_op_e;

  typedef struct packed {
    logic [LSU_INST_ID_BITS-1:0]              id;
    logic [31:0]                              instr;
    logic [63:0]                              pc;
    logic [LSU_MAX_OPERANDS-1:0]              prn_in_valid;
    logic [LSU_MAX_OPERANDS-1:0]              prn_in_ready;
    logic [LSU_MAX_OPERANDS*LSU_PRN_BITS-1:0] prn_in;
    logic [LSU_MAX_OPERANDS-1:0]              prn_out_valid;
    logic [LSU_MAX_OPERANDS*LSU_PRN_BITS-1:0] prn_out;
  } lsu_entry_t;

  function automatic lsu_op_e decode_op(input logic [31:0] instr);
    if ((instr & LDST_MASK) == LDUR_MATCH) return OP_LOAD;
    if ((instr & LDST_MASK) == STUR_MATCH) return OP_STORE;
    return OP_NOP;
  endfunction

  function automatic logic [63:0] imm9_sext(input logic [31:0] instr);
    return {{55{instr[20]}}, instr[20:12]};
  endfunction

endpackage

// File: rtl/lsu_issue_unit_if.sv
// Memory-side bus of the load/store unit: one read channel with a valid
// return and one single-cycle write strobe.
interface lsu_issue_unit_if;
  logic        mem_ren;
  logic [63:0] mem_raddr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_wen;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;

  modport master (
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
    input  mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
    output mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order circular issue queue: snoops every FU's wake-up bus to mark
// source operands ready and offers only the head entry for issue.
module lsu_issue_queue
  import lsu_pkg::*;
#(
  parameter int PRN_BITS     = LSU_PRN_BITS,
  parameter int MAX_OPERANDS = LSU_MAX_OPERANDS,
  parameter int FU_COUNT     = 4,
  parameter int FU_INDEX     = 1,
  parameter int QUEUE_SIZE   = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          inst_valid,
  output logic                                          queue_ready,
  input  lsu_entry_t                                    inst_entry,
  input  logic [(FU_COUNT-1)*MAX_OPERANDS-1:0]          set_prn_ready,
  input  logic [(FU_COUNT-1)*MAX_OPERANDS*PRN_BITS-1:0] set_prn,
  input  logic [MAX_OPERANDS-1:0]                       own_wake_valid,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0]              own_wake_prn,
  input  logic                                          issue_allow,
  output logic                                          issue_valid,
  output lsu_entry_t                                    issue_entry
);

  localparam int WAKE_SLOTS = FU_COUNT * MAX_OPERANDS;
  localparam int PTR_W      = $clog2(QUEUE_SIZE);
  localparam int CNT_W      = $clog2(QUEUE_SIZE + 1);

  logic [WAKE_SLOTS-1:0]          wake_valid;
  logic [WAKE_SLOTS*PRN_BITS-1:0] wake_prn;

  // Own result bus sits at FU_INDEX; external buses fill the other slots in order.
  for (genvar f = 0; f < FU_COUNT; f++) begin : g_wake
    if (f == FU_INDEX) begin : g_own
      assign wake_valid[f*MAX_OPERANDS +: MAX_OPERANDS]                = own_wake_valid;
      assign wake_prn[f*MAX_OPERANDS*PRN_BITS +: MAX_OPERANDS*PRN_BITS] = own_wake_prn;
    end else begin : g_ext
      localparam int EXT = (f < FU_INDEX) ? f : f - 1;
      assign wake_valid[f*MAX_OPERANDS +: MAX_OPERANDS] =
        set_prn_ready[EXT*MAX_OPERANDS +: MAX_OPERANDS];
      assign wake_prn[f*MAX_OPERANDS*PRN_BITS +: MAX_OPERANDS*PRN_BITS] =
        set_prn[EXT*MAX_OPERANDS*PRN_BITS +: MAX_OPERANDS*PRN_BITS];
    end
  end

  function automatic logic wake_hit(input logic [WAKE_SLOTS-1:0]          v,
                                    input logic [WAKE_SLOTS*PRN_BITS-1:0] p,
                                    input logic [PRN_BITS-1:0]            prn);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < WAKE_SLOTS; s++)
      if (v[s] && (p[s*PRN_BITS +: PRN_BITS] == prn)) hit = 1'b1;
    return hit;
  endfunction

  lsu_entry_t       q [QUEUE_SIZE];
  lsu_entry_t       enq_entry;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             enq;

  assign queue_ready = (count != CNT_W'(QUEUE_SIZE));
  assign enq         = inst_valid && queue_ready;
  assign issue_entry = q[head];
  assign issue_valid = (count != '0) && (&issue_entry.prn_in_ready) && issue_allow;

  always_comb begin
    enq_entry = inst_entry;
    for (int j = 0; j < MAX_OPERANDS; j++)
      enq_entry.prn_in_ready[j] = !inst_entry.prn_in_valid[j] || inst_entry.prn_in_ready[j] ||
                                  wake_hit(wake_valid, wake_prn, inst_entry.prn_in[j*PRN_BITS +: PRN_BITS]);
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(QUEUE_SIZE - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: <= in clocked blocks so every register samples pre-edge values.
      if (enq)         tail <= ptr_inc(tail);
      if (issue_valid) head <= ptr_inc(head);
      if (enq && !issue_valid)      count <= count + 1'b1;
      else if (!enq && issue_valid) count <= count - 1'b1;
    end
  end

  // NOTE: the entry array is not reset; head/tail/count alone say which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_SIZE; i++)
      for (int j = 0; j < MAX_OPERANDS; j++)
        if (wake_hit(wake_valid, wake_prn, q[i].prn_in[j*PRN_BITS +: PRN_BITS]))
          q[i].prn_in_ready[j] <= 1'b1;
    if (enq) q[tail] <= enq_entry;
  end

endmodule

// File: rtl/lsu_issue_unit.sv
// Load/store FU slice: in-order issue queue feeding a single 64-bit LDUR/STUR
// execution FSM. Define LSU_TRACE_EN to print each completing instruction id.
module lsu_issue_unit
  import lsu_pkg::*;
#(
  parameter int INST_ID_BITS = LSU_INST_ID_BITS,
  parameter int PRN_BITS     = LSU_PRN_BITS,
  parameter int MAX_OPERANDS = LSU_MAX_OPERANDS,
  parameter int FU_COUNT     = 4,
  parameter int FU_INDEX     = 1,
  parameter int QUEUE_SIZE   = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          inst_valid,
  output logic                                          queue_ready,
  input  logic [INST_ID_BITS-1:0]                       inst_id,
  input  logic [31:0]                                   raw_instr,
  input  logic [63:0]                                   instr_pc,
  input  logic [MAX_OPERANDS-1:0]                       prn_input_valid,
  input  logic [MAX_OPERANDS-1:0]                       prn_input_ready,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0]              prn_input,
  input  logic [MAX_OPERANDS-1:0]                       prn_output_valid,
  input  logic [MAX_OPERANDS*PRN_BITS-1:0]              prn_output,
  input  logic [(FU_COUNT-1)*MAX_OPERANDS-1:0]          set_prn_ready,
  input  logic [(FU_COUNT-1)*MAX_OPERANDS*PRN_BITS-1:0] set_prn,
  input  logic [MAX_OPERANDS*64-1:0]                    prf_op,
  output logic [MAX_OPERANDS-1:0]                       prf_read_enable,
  output logic [MAX_OPERANDS*PRN_BITS-1:0]              prf_read_prn,
  output logic [MAX_OPERANDS*64-1:0]                    prf_write,
  output logic [MAX_OPERANDS-1:0]                       prf_write_enable,
  output logic [MAX_OPERANDS*PRN_BITS-1:0]              prf_write_prn,
  output logic [INST_ID_BITS-1:0]                       fu_out_inst_id,
  output logic                                          fu_out_valid,
  lsu_issue_unit_if.master                              mem
);

  lsu_state_e state, state_nxt;
  lsu_entry_t inst_entry, issue_entry;
  lsu_op_e    issue_op;
  logic       issue_valid, issue_allow;

  logic [INST_ID_BITS-1:0]          id_q;
  logic [MAX_OPERANDS-1:0]          out_valid_q;
  logic [MAX_OPERANDS*PRN_BITS-1:0] out_prn_q;
  logic [63:0]                      addr_q, wdata_q, load_data_q;
  logic [63:0]                      op0, op1;
  logic                             unused_bits;

  assign inst_entry = '{id: inst_id, instr: raw_instr, pc: instr_pc,
                        prn_in_valid: prn_input_valid, prn_in_ready: prn_input_ready,
                        prn_in: prn_input, prn_out_valid: prn_output_valid,
                        prn_out: prn_output};

  // DONE counts as free so a ready head can issue back-to-back with a completion.
  assign issue_allow = (state == LSU_IDLE) || (state == LSU_DONE);

  lsu_issue_queue #(
    .PRN_BITS     (PRN_BITS),
    .MAX_OPERANDS (MAX_OPERANDS),
    .FU_COUNT     (FU_COUNT),
    .FU_INDEX     (FU_INDEX),
    .QUEUE_SIZE   (QUEUE_SIZE)
  ) u_queue (
    .clk            (clk),
    .rst            (rst),
    .inst_valid     (inst_valid),
    .queue_ready    (queue_ready),
    .inst_entry     (inst_entry),
    .set_prn_ready  (set_prn_ready),
    .set_prn        (set_prn),
    .own_wake_valid (prf_write_enable),
    .own_wake_prn   (prf_write_prn),
    .issue_allow    (issue_allow),
    .issue_valid    (issue_valid),
    .issue_entry    (issue_entry)
  );

  assign issue_op    = decode_op(issue_entry.instr);
  assign op0         = prf_op[63:0];
  assign op1         = prf_op[127:64];
  assign unused_bits = ^{issue_entry.pc, issue_entry.prn_in_ready, prf_op[MAX_OPERANDS*64-1:128]};

  assign prf_read_enable = issue_valid ? issue_entry.prn_in_valid : '0;
  assign prf_read_prn    = issue_valid ? issue_entry.prn_in       : '0;

  always_ff @(posedge clk) begin
    if (!rst) state <= LSU_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path drives every output; no latches.
    state_nxt        = state;
    mem.mem_ren      = 1'b0;
    mem.mem_raddr    = '0;
    mem.mem_wen      = 1'b0;
    mem.mem_waddr    = '0;
    mem.mem_wdata    = '0;
    fu_out_valid     = 1'b0;
    fu_out_inst_id   = '0;
    prf_write        = '0;
    prf_write_enable = '0;
    prf_write_prn    = '0;
    case (state)
      LSU_IDLE, LSU_DONE: begin
        if (state == LSU_DONE) begin
          fu_out_valid     = 1'b1;
          fu_out_inst_id   = id_q;
          prf_write[63:0]  = load_data_q;
          prf_write_enable = out_valid_q;
          prf_write_prn    = out_prn_q;
        end
        state_nxt = LSU_IDLE;
        if (issue_valid) begin
          case (issue_op)
            OP_LOAD:  state_nxt = LSU_LOAD_WAIT;
            OP_STORE: state_nxt = LSU_STORE;
            default:  state_nxt = LSU_DONE;
          endcase
        end
      end
      LSU_LOAD_WAIT: begin
        mem.mem_ren   = 1'b1;
        mem.mem_raddr = addr_q;
        if (mem.mem_rvalid) state_nxt = LSU_DONE;
      end
      LSU_STORE: begin
        mem.mem_wen   = 1'b1;
        mem.mem_waddr = addr_q;
        mem.mem_wdata = wdata_q;
        state_nxt     = LSU_DONE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_q        <= '0;
      out_valid_q <= '0;
      out_prn_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      if (issue_valid) begin
        id_q        <= issue_entry.id;
        out_valid_q <= issue_entry.prn_out_valid;
        out_prn_q   <= issue_entry.prn_out;
        addr_q      <= op0 + imm9_sext(issue_entry.instr);
        wdata_q     <= op1;
        load_data_q <= '0;
      end
      if (state == LSU_LOAD_WAIT && mem.mem_rvalid) load_data_q <= mem.mem_rdata;
    end
  end

`ifdef LSU_TRACE_EN
  always @(posedge clk)
    if (rst && fu_out_valid) $display("LSU FU Finished Instruction ID: %0d", fu_out_inst_id);
`else
`endif

endmodule

// File: tb/tb_lsu_issue_unit.sv
// Directed bench for lsu_issue_unit: queue fill, load, store, in-order wake-up,
// same-cycle wake-up, own-bus wake-up and reset during an outstanding load.
module tb_lsu_issue_unit;

  localparam logic [31:0] NOP_I  = 32'hD503201F;
  localparam logic [31:0] LDUR_I = 32'hF8408041;  // LDUR X1,[X2,#8]
  localparam logic [31:0] STUR_I = 32'hF81F8043;  // STUR X3,[X2,#-8]

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inst_valid;
  logic         queue_ready;
  logic [5:0]   inst_id;
  logic [31:0]  raw_instr;
  logic [63:0]  instr_pc;
  logic [2:0]   prn_input_valid, prn_input_ready, prn_output_valid;
  logic [17:0]  prn_input, prn_output;
  logic [8:0]   set_prn_ready;
  logic [53:0]  set_prn;
  logic [191:0] prf_op;
  logic [2:0]   prf_read_enable, prf_write_enable;
  logic [17:0]  prf_read_prn, prf_write_prn;
  logic [191:0] prf_write;
  logic [5:0]   fu_out_inst_id;
  logic         fu_out_valid;

  lsu_issue_unit_if mem_bus ();

  lsu_issue_unit dut (
    .clk              (clk),
    .rst              (rst),
    .inst_valid       (inst_valid),
    .queue_ready      (queue_ready),
    .inst_id          (inst_id),
    .raw_instr        (raw_instr),
    .instr_pc         (instr_pc),
    .prn_input_valid  (prn_input_valid),
    .prn_input_ready  (prn_input_ready),
    .prn_input        (prn_input),
    .prn_output_valid (prn_output_valid),
    .prn_output       (prn_output),
    .set_prn_ready    (set_prn_ready),
    .set_prn          (set_prn),
    .prf_op           (prf_op),
    .prf_read_enable  (prf_read_enable),
    .prf_read_prn     (prf_read_prn),
    .prf_write        (prf_write),
    .prf_write_enable (prf_write_enable),
    .prf_write_prn    (prf_write_prn),
    .fu_out_inst_id   (fu_out_inst_id),
    .fu_out_valid     (fu_out_valid),
    .mem              (mem_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [5:0] got_id[$];
  int         got_cyc[$];

  task automatic clear_inputs();
    inst_valid = 1'b0; inst_id = '0; raw_instr = '0; instr_pc = '0;
    prn_input_valid = '0; prn_input_ready = '0; prn_input = '0;
    prn_output_valid = '0; prn_output = '0;
    set_prn_ready = '0; set_prn = '0;
    prf_op = {64'h0, 64'h55, 64'h1000};
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
  endtask

  // Presents one instruction for a single cycle; returns at the following negedge.
  task automatic enq(input logic [5:0] id, input logic [31:0] ins,
                     input logic [2:0] vin, input logic [2:0] rin,
                     input logic [5:0] p0, input logic [5:0] p1,
                     input logic [2:0] ov, input logic [5:0] o0);
    inst_id = id; raw_instr = ins; instr_pc = 64'h4000 + 64'(id);
    prn_input_valid = vin; prn_input_ready = rin; prn_input = {6'd0, p1, p0};
    prn_output_valid = ov; prn_output = {12'd0, o0};
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  task automatic collect(input int n);
    got_id.delete();
    got_cyc.delete();
    for (int k = 0; k < n; k++) begin
      if (fu_out_valid) begin
        got_id.push_back(fu_out_inst_id);
        got_cyc.push_back(cyc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (queue_ready !== 1'b1) begin errors++; $display("FAIL reset_queue_ready got %b exp 1", queue_ready); end
    checks++; if (fu_out_valid !== 1'b0) begin errors++; $display("FAIL reset_fu_out_valid got %b exp 0", fu_out_valid); end
    checks++; if ({mem_bus.mem_ren, mem_bus.mem_wen} !== 2'b00) begin errors++; $display("FAIL reset_mem got %b exp 00", {mem_bus.mem_ren, mem_bus.mem_wen}); end
    checks++; if ({prf_read_enable, prf_write_enable} !== 6'd0) begin errors++; $display("FAIL reset_prf_en got %b exp 0", {prf_read_enable, prf_write_enable}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_queue_full();
    for (int i = 0; i < 4; i++) enq(6'(1 + i), NOP_I, 3'b001, 3'b000, 6'(20 + i), 6'd0, 3'b000, 6'd0);
    checks++; if (queue_ready !== 1'b0) begin errors++; $display("FAIL full_queue_ready got %b exp 0", queue_ready); end
    checks++; if (prf_read_enable !== 3'b000) begin errors++; $display("FAIL full_no_issue got %b exp 000", prf_read_enable); end
    enq(6'd5, NOP_I, 3'b001, 3'b001, 6'd1, 6'd0, 3'b000, 6'd0);
    checks++; if (queue_ready !== 1'b0) begin errors++; $display("FAIL full_fifth_queue_ready got %b exp 0", queue_ready); end
    set_prn_ready = 9'b0_0000_1111;
    set_prn = {30'd0, 6'd23, 6'd22, 6'd21, 6'd20};
    @(negedge clk);
    set_prn_ready = '0; set_prn = '0;
    collect(10);
    checks++; if (got_id.size() !== 4) begin errors++; $display("FAIL drain_count got %0d exp 4", got_id.size()); end
    for (int i = 0; i < got_id.size() && i < 4; i++) begin
      checks++; if (got_id[i] !== 6'(1 + i)) begin errors++; $display("FAIL drain_order[%0d] got %0d exp %0d", i, got_id[i], 1 + i); end
    end
    if (got_id.size() == 4) begin
      checks++; if (got_cyc[3] - got_cyc[0] !== 3) begin errors++; $display("FAIL drain_back_to_back span got %0d exp 3", got_cyc[3] - got_cyc[0]); end
    end
    checks++; if (queue_ready !== 1'b1) begin errors++; $display("FAIL drain_queue_ready got %b exp 1", queue_ready); end
  endtask

  task automatic test_load();
    enq(6'd10, LDUR_I, 3'b001, 3'b001, 6'd2, 6'd0, 3'b001, 6'd1);
    #1;
    checks++; if (prf_read_enable !== 3'b001) begin errors++; $display("FAIL ld_read_en got %b exp 001", prf_read_enable); end
    checks++; if (prf_read_prn[5:0] !== 6'd2) begin errors++; $display("FAIL ld_read_prn got %0d exp 2", prf_read_prn[5:0]); end
    @(negedge clk);
    checks++; if (mem_bus.mem_ren !== 1'b1) begin errors++; $display("FAIL ld_ren got %b exp 1", mem_bus.mem_ren); end
    checks++; if (mem_bus.mem_raddr !== 64'h1008) begin errors++; $display("FAIL ld_raddr got %h exp 1008", mem_bus.mem_raddr); end
    @(negedge clk);
    checks++; if ({mem_bus.mem_ren, fu_out_valid} !== 2'b10) begin errors++; $display("FAIL ld_wait got %b exp 10", {mem_bus.mem_ren, fu_out_valid}); end
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 64'hDEAD;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    checks++; if ({fu_out_valid, fu_out_inst_id} !== {1'b1, 6'd10}) begin errors++; $display("FAIL ld_done got %b/%0d exp 1/10", fu_out_valid, fu_out_inst_id); end
    checks++; if (prf_write[63:0] !== 64'hDEAD) begin errors++; $display("FAIL ld_wdata got %h exp dead", prf_write[63:0]); end
    checks++; if (prf_write_enable !== 3'b001) begin errors++; $display("FAIL ld_we got %b exp 001", prf_write_enable); end
    checks++; if (prf_write_prn[5:0] !== 6'd1) begin errors++; $display("FAIL ld_wprn got %0d exp 1", prf_write_prn[5:0]); end
    @(negedge clk);
    checks++; if ({fu_out_valid, mem_bus.mem_ren} !== 2'b00) begin errors++; $display("FAIL ld_after got %b exp 00", {fu_out_valid, mem_bus.mem_ren}); end
  endtask

  task automatic test_store();
    enq(6'd11, STUR_I, 3'b011, 3'b011, 6'd2, 6'd3, 3'b000, 6'd0);
    #1;
    checks++; if (prf_read_enable !== 3'b011) begin errors++; $display("FAIL st_read_en got %b exp 011", prf_read_enable); end
    @(negedge clk);
    checks++; if ({mem_bus.mem_wen, fu_out_valid} !== 2'b10) begin errors++; $display("FAIL st_wen got %b exp 10", {mem_bus.mem_wen, fu_out_valid}); end
    checks++; if (mem_bus.mem_waddr !== 64'hFF8) begin errors++; $display("FAIL st_waddr got %h exp ff8", mem_bus.mem_waddr); end
    checks++; if (mem_bus.mem_wdata !== 64'h55) begin errors++; $display("FAIL st_wdata got %h exp 55", mem_bus.mem_wdata); end
    @(negedge clk);
    checks++; if ({mem_bus.mem_wen, fu_out_valid, fu_out_inst_id} !== {2'b01, 6'd11}) begin errors++; $display("FAIL st_done got %b/%b/%0d exp 0/1/11", mem_bus.mem_wen, fu_out_valid, fu_out_inst_id); end
    checks++; if (prf_write_enable !== 3'b000) begin errors++; $display("FAIL st_we got %b exp 000", prf_write_enable); end
    @(negedge clk);
    checks++; if (fu_out_valid !== 1'b0) begin errors++; $display("FAIL st_single_done got %b exp 0", fu_out_valid); end
  endtask

  task automatic test_in_order_wakeup();
    enq(6'd20, NOP_I, 3'b001, 3'b000, 6'd7, 6'd0, 3'b000, 6'd0);
    enq(6'd21, NOP_I, 3'b001, 3'b001, 6'd3, 6'd0, 3'b000, 6'd0);
    set_prn_ready = 9'b0_1000_0000;
    set_prn = {6'd0, 6'd8, 42'd0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_prn_ready = '0; set_prn = '0;
      checks++; if ({prf_read_enable, fu_out_valid} !== 4'b0000) begin errors++; $display("FAIL order_blocked[%0d] got %b exp 0000", k, {prf_read_enable, fu_out_valid}); end
    end
    set_prn_ready = 9'b0_1000_0000;
    set_prn = {6'd0, 6'd7, 42'd0};
    @(negedge clk);
    set_prn_ready = '0; set_prn = '0;
    collect(6);
    checks++; if (got_id.size() !== 2) begin errors++; $display("FAIL order_count got %0d exp 2", got_id.size()); end
    if (got_id.size() == 2) begin
      checks++; if ({got_id[0], got_id[1]} !== {6'd20, 6'd21}) begin errors++; $display("FAIL order_ids got %0d,%0d exp 20,21", got_id[0], got_id[1]); end
    end
  endtask

  task automatic test_same_cycle_wakeup();
    set_prn_ready = 9'b0_0000_0001;
    set_prn = {48'd0, 6'd12};
    enq(6'd30, NOP_I, 3'b001, 3'b000, 6'd12, 6'd0, 3'b000, 6'd0);
    set_prn_ready = '0; set_prn = '0;
    #1;
    checks++; if ({prf_read_enable, prf_read_prn[5:0]} !== {3'b001, 6'd12}) begin errors++; $display("FAIL same_cycle_issue got %b/%0d exp 001/12", prf_read_enable, prf_read_prn[5:0]); end
    @(negedge clk);
    checks++; if ({fu_out_valid, fu_out_inst_id} !== {1'b1, 6'd30}) begin errors++; $display("FAIL same_cycle_done got %b/%0d exp 1/30", fu_out_valid, fu_out_inst_id); end
    @(negedge clk);
  endtask

  task automatic test_own_wakeup();
    enq(6'd40, LDUR_I, 3'b001, 3'b001, 6'd2, 6'd0, 3'b001, 6'd9);
    enq(6'd41, STUR_I, 3'b011, 3'b001, 6'd2, 6'd9, 3'b000, 6'd0);
    checks++; if (mem_bus.mem_ren !== 1'b1) begin errors++; $display("FAIL own_ld_ren got %b exp 1", mem_bus.mem_ren); end
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 64'h1234;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    checks++; if ({fu_out_valid, fu_out_inst_id, prf_write_enable, prf_write_prn[5:0]} !== {1'b1, 6'd40, 3'b001, 6'd9}) begin errors++; $display("FAIL own_ld_done got %b/%0d/%b/%0d exp 1/40/001/9", fu_out_valid, fu_out_inst_id, prf_write_enable, prf_write_prn[5:0]); end
    checks++; if (prf_write[63:0] !== 64'h1234) begin errors++; $display("FAIL own_ld_data got %h exp 1234", prf_write[63:0]); end
    checks++; if (prf_read_enable !== 3'b000) begin errors++; $display("FAIL own_st_early got %b exp 000", prf_read_enable); end
    @(negedge clk);
    checks++; if ({prf_read_enable, prf_read_prn} !== {3'b011, 6'd0, 6'd9, 6'd2}) begin errors++; $display("FAIL own_st_issue got %b/%h exp 011/00242", prf_read_enable, prf_read_prn); end
    @(negedge clk);
    checks++; if ({mem_bus.mem_wen, mem_bus.mem_waddr, mem_bus.mem_wdata} !== {1'b1, 64'hFF8, 64'h55}) begin errors++; $display("FAIL own_st_write got %b/%h/%h exp 1/ff8/55", mem_bus.mem_wen, mem_bus.mem_waddr, mem_bus.mem_wdata); end
    @(negedge clk);
    checks++; if ({fu_out_valid, fu_out_inst_id} !== {1'b1, 6'd41}) begin errors++; $display("FAIL own_st_done got %b/%0d exp 1/41", fu_out_valid, fu_out_inst_id); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    enq(6'd50, LDUR_I, 3'b001, 3'b001, 6'd2, 6'd0, 3'b001, 6'd1);
    enq(6'd51, NOP_I, 3'b000, 3'b000, 6'd0, 6'd0, 3'b000, 6'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if ({mem_bus.mem_ren, queue_ready, fu_out_valid} !== 3'b010) begin errors++; $display("FAIL rst_mid_state got %b exp 010", {mem_bus.mem_ren, queue_ready, fu_out_valid}); end
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 64'hBAD;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    collect(4);
    checks++; if (got_id.size() !== 0) begin errors++; $display("FAIL rst_mid_orphan got %0d completions exp 0", got_id.size()); end
  endtask

  initial begin
    test_reset();
    test_queue_full();
    test_load();
    test_store();
    test_in_order_wakeup();
    test_same_cycle_wakeup();
    test_own_wakeup();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
